// File: rtl/ahbl_excl_monitor.sv
// ahbl_excl_monitor: AHB-Lite exclusive-access global monitor between an arbiter and a shared slave.
// Keeps one reservation per master ID, passes ordinary transfers straight through,
// drops failed exclusive stores locally and reports hexokay in the data phase.
// Ports: src_* face the arbiter's master port, dst_* face the slave; clk/rst async active-high.
// Optional feature: define EXCL_MON_SNOOP_EN so plain writes clear matching reservations.
module ahbl_excl_monitor #(
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int N_MASTERS = 2,
  parameter int W_GRANULE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_hready,
  output logic              src_hready_resp,
  output logic              src_hresp,
  input  logic [W_ADDR-1:0] src_haddr,
  input  logic              src_hwrite,
  input  logic [1:0]        src_htrans,
  input  logic [2:0]        src_hsize,
  input  logic [2:0]        src_hburst,
  input  logic [3:0]        src_hprot,
  input  logic              src_hmastlock,
  input  logic [W_DATA-1:0] src_hwdata,
  output logic [W_DATA-1:0] src_hrdata,
  input  logic              src_hexcl,
  input  logic [7:0]        src_hmaster,
  output logic              src_hexokay,
  output logic              dst_hready,
  input  logic              dst_hready_resp,
  input  logic              dst_hresp,
  output logic [W_ADDR-1:0] dst_haddr,
  output logic              dst_hwrite,
  output logic [1:0]        dst_htrans,
  output logic [2:0]        dst_hsize,
  output logic [2:0]        dst_hburst,
  output logic [3:0]        dst_hprot,
  output logic              dst_hmastlock,
  output logic [W_DATA-1:0] dst_hwdata,
  input  logic [W_DATA-1:0] dst_hrdata
);
  localparam int W_TAG = W_ADDR - W_GRANULE;
  logic                            aphase, excl_ld, excl_st, slot_ok, pass, st_fail;
  logic [W_TAG-1:0]                tag;
  logic [N_MASTERS-1:0]            sel, hit, valid_q, valid_d;
  logic [N_MASTERS-1:0][W_TAG-1:0] addr_q, addr_d;
  logic                            dp_excl_q, dp_excl_d, dp_okay_q, dp_okay_d;
  logic                            dp_local_q, dp_local_d, dp_load_q, dp_load_d;
  logic [7:0]                      dp_master_q, dp_master_d;
  assign aphase  = src_hready & src_htrans[1];
  assign excl_ld = aphase & src_hexcl & ~src_hwrite;
  assign excl_st = aphase & src_hexcl & src_hwrite;
  assign tag     = src_haddr[W_ADDR-1:W_GRANULE];
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_slot
    assign sel[i] = src_hmaster == 8'(i);
    assign hit[i] = addr_q[i] == tag;
  end
  // IDs outside the slot range select nothing, so they never pass and never touch state
  assign slot_ok = |sel;
  assign pass    = |(sel & valid_q & hit);
  assign st_fail = excl_st & ~pass;
  // Error clear is applied first so a same-edge address-phase update to that slot wins
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (dp_load_q && dst_hresp && dp_master_q == 8'(i)) valid_d[i] = 1'b0;
      if (excl_ld && sel[i]) begin
        valid_d[i] = 1'b1;
        addr_d[i]  = tag;
      end
      else if (excl_st && (pass ? hit[i] : sel[i])) valid_d[i] = 1'b0;
`ifdef EXCL_MON_SNOOP_EN
      else if (aphase && !src_hexcl && src_hwrite && hit[i]) valid_d[i] = 1'b0;
`endif
    end
  end
  always_comb begin
    dp_excl_d   = src_hready ? aphase & src_hexcl : dp_excl_q;
    dp_okay_d   = src_hready ? (excl_ld & slot_ok) | (excl_st & pass) : dp_okay_q;
    dp_local_d  = src_hready ? st_fail : dp_local_q;
    dp_load_d   = src_hready ? excl_ld : dp_load_q;
    dp_master_d = src_hready ? (aphase ? src_hmaster : 8'h00) : dp_master_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      addr_q      <= '0;
      dp_excl_q   <= 1'b0;
      dp_okay_q   <= 1'b0;
      dp_local_q  <= 1'b0;
      dp_load_q   <= 1'b0;
      dp_master_q <= 8'h00;
    end else begin
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      dp_excl_q   <= dp_excl_d;
      dp_okay_q   <= dp_okay_d;
      dp_local_q  <= dp_local_d;
      dp_load_q   <= dp_load_d;
      dp_master_q <= dp_master_d;
    end
  end
  // A failed store never reaches the slave; its one-cycle OKAY data phase is produced here
  assign src_hready_resp = dp_local_q | dst_hready_resp;
  assign src_hresp       = ~dp_local_q & dst_hresp;
  assign src_hexokay     = dp_excl_q & dp_okay_q & src_hready_resp;
  assign src_hrdata      = dst_hrdata;
  assign dst_hready      = src_hready;
  assign dst_htrans      = st_fail ? 2'b00 : src_htrans;
  assign dst_haddr       = src_haddr;
  assign dst_hwrite      = src_hwrite;
  assign dst_hsize       = src_hsize;
  assign dst_hburst      = src_hburst;
  assign dst_hprot       = src_hprot;
  assign dst_hmastlock   = src_hmastlock;
  assign dst_hwdata      = src_hwdata;
endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// tb_ahbl_excl_monitor: directed table-driven bench for ahbl_excl_monitor with a small slave memory model.
module tb_ahbl_excl_monitor;
`ifdef EXCL_MON_SNOOP_EN
  localparam bit SNOOP = 1'b1;
`else
  localparam bit SNOOP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst;
  logic        src_hready, src_hready_resp, src_hresp, src_hwrite, src_hmastlock, src_hexcl, src_hexokay;
  logic [31:0] src_haddr, src_hwdata, src_hrdata;
  logic [1:0]  src_htrans;
  logic [2:0]  src_hsize, src_hburst;
  logic [3:0]  src_hprot;
  logic [7:0]  src_hmaster;
  logic        dst_hready, dst_hready_resp, dst_hresp, dst_hwrite, dst_hmastlock;
  logic [31:0] dst_haddr, dst_hwdata, dst_hrdata;
  logic [1:0]  dst_htrans;
  logic [2:0]  dst_hsize, dst_hburst;
  logic [3:0]  dst_hprot;
  always #5 clk = ~clk;
  assign src_hready = src_hready_resp;
  ahbl_excl_monitor dut (
    .clk(clk), .rst(rst),
    .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
    .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
    .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
    .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
    .src_hexcl(src_hexcl), .src_hmaster(src_hmaster), .src_hexokay(src_hexokay),
    .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
    .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
    .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
    .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata)
  );
  // slave model: word memory, programmable wait states, optional two-cycle ERROR response
  logic [31:0] mem [1024];
  int          ws_cfg = 0;
  logic        err_cfg = 1'b0;
  logic        s_act, s_wr, s_err, s_errph;
  logic [9:0]  s_idx;
  int          s_ws;
  assign dst_hready_resp = !s_act || (s_err ? s_errph : s_ws == 0);
  assign dst_hresp       = s_act && s_err;
  assign dst_hrdata      = s_act ? mem[s_idx] : 32'h0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_act <= 1'b0; s_wr <= 1'b0; s_err <= 1'b0; s_errph <= 1'b0; s_idx <= '0; s_ws <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else begin
      if (s_act && dst_hready_resp) begin
        if (s_wr && !s_err) mem[s_idx] <= dst_hwdata;
        s_act <= 1'b0;
      end else if (s_act) begin
        if (s_err) s_errph <= 1'b1;
        else s_ws <= s_ws - 1;
      end
      if (dst_hready && dst_htrans[1]) begin
        s_act <= 1'b1; s_wr <= dst_hwrite; s_idx <= dst_haddr[11:2];
        s_ws <= ws_cfg; s_err <= err_cfg; s_errph <= 1'b0;
      end
    end
  end
  typedef struct {
    logic [7:0]  m;
    logic [31:0] a;
    logic        w, x;
    logic [31:0] wd;
    logic        ok, sup, rchk;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[$];
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wait_dp(output int cyc, output logic early);
    cyc = 0; early = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (!src_hready) early |= src_hexokay;
    end while (!src_hready && cyc < 20);
  endtask
  task automatic xfer(input logic [7:0] m, input logic [31:0] a, input logic w, input logic x,
                      input logic [31:0] wd, output logic ok, output logic resp, output logic [31:0] rd,
                      output logic [1:0] dtr, output int cyc, output logic early);
    src_hmaster = m; src_haddr = a; src_hwrite = w; src_hexcl = x; src_htrans = 2'b10;
    @(negedge clk);
    dtr = dst_htrans;
    @(posedge clk); #1;
    src_htrans = 2'b00; src_hexcl = 1'b0; src_hwdata = wd;
    wait_dp(cyc, early);
    ok = src_hexokay; resp = src_hresp; rd = src_hrdata;
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic ok_v, resp_v, early_v;
    logic [31:0] rd_v;
    logic [1:0] dtr_v;
    int cyc_v;
    rst = 1'b1;
    src_haddr = '0; src_hwrite = 1'b0; src_htrans = 2'b00; src_hsize = 3'd2; src_hburst = 3'd0;
    src_hprot = 4'h3; src_hmastlock = 1'b0; src_hwdata = '0; src_hexcl = 1'b0; src_hmaster = '0;
    //           m      addr        w     x     wdata         ok     sup    rchk  rdata
    tbl.push_back('{8'd0, 32'h100, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd0, 32'h100, 1'b1, 1'b1, 32'hAAAA0001, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd0, 32'h100, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hAAAA0001});
    tbl.push_back('{8'd1, 32'h200, 1'b1, 1'b1, 32'hBBBB0002, 1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{8'd1, 32'h200, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0});
    tbl.push_back('{8'd0, 32'h104, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd1, 32'h100, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd1, 32'h100, 1'b1, 1'b1, 32'hCCCC0003, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd0, 32'h104, 1'b1, 1'b1, 32'hDDDD0004, 1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{8'd0, 32'h104, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0});
    tbl.push_back('{8'd0, 32'h100, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hCCCC0003});
    tbl.push_back('{8'd0, 32'h300, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd1, 32'h304, 1'b1, 1'b0, 32'hEEEE0005, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd0, 32'h300, 1'b1, 1'b1, 32'hFFFF0006, !SNOOP, SNOOP, 1'b0, 32'h0});
    tbl.push_back('{8'd5, 32'h400, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd5, 32'h400, 1'b1, 1'b1, 32'h12340007, 1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{8'd1, 32'h500, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd1, 32'h500, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd1, 32'h500, 1'b1, 1'b1, 32'h55550008, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd1, 32'h500, 1'b1, 1'b1, 32'h55550009, 1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{8'd0, 32'h900, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd0, 32'h908, 1'b1, 1'b1, 32'h9999000A, 1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{8'd0, 32'h900, 1'b1, 1'b1, 32'h9999000B, 1'b0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{8'd0, 32'hA00, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd0, 32'hA07, 1'b1, 1'b1, 32'h5A5A000C, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{8'd0, 32'hA04, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h5A5A000C});
    repeat (2) @(posedge clk);
    src_htrans = 2'b10; src_haddr = 32'h123; src_hmastlock = 1'b1;
    #1;
    chk("reset dst_htrans", 32'(dst_htrans), 32'h2);
    chk("reset dst_haddr", dst_haddr, 32'h123);
    chk("reset dst_hmastlock", 32'(dst_hmastlock), 32'h1);
    chk("reset hexokay", 32'(src_hexokay), 32'h0);
    chk("reset hready_resp", 32'(src_hready_resp), 32'h1);
    chk("reset hresp", 32'(src_hresp), 32'h0);
    src_htrans = 2'b00; src_hmastlock = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < tbl.size(); k++) begin
      xfer(tbl[k].m, tbl[k].a, tbl[k].w, tbl[k].x, tbl[k].wd, ok_v, resp_v, rd_v, dtr_v, cyc_v, early_v);
      chk($sformatf("v%0d hexokay", k), 32'(ok_v), 32'(tbl[k].ok));
      chk($sformatf("v%0d dst_htrans", k), 32'(dtr_v), tbl[k].sup ? 32'h0 : 32'h2);
      chk($sformatf("v%0d hresp", k), 32'(resp_v), 32'h0);
      chk($sformatf("v%0d cycles", k), 32'(cyc_v), 32'h1);
      if (tbl[k].rchk) chk($sformatf("v%0d rdata", k), rd_v, tbl[k].rd);
    end
    ws_cfg = 3;
    src_hmaster = 8'd0; src_haddr = 32'h600; src_hwrite = 1'b0; src_hexcl = 1'b1; src_htrans = 2'b10;
    @(posedge clk); #1;
    src_hwrite = 1'b1;
    wait_dp(cyc_v, early_v);
    chk("ws load cycles", 32'(cyc_v), 32'h4);
    chk("ws load early hexokay", 32'(early_v), 32'h0);
    chk("ws load hexokay", 32'(src_hexokay), 32'h1);
    chk("ws store dst_htrans", 32'(dst_htrans), 32'h2);
    @(posedge clk); #1;
    src_htrans = 2'b00; src_hexcl = 1'b0; src_hwdata = 32'h600D0600;
    wait_dp(cyc_v, early_v);
    chk("ws store cycles", 32'(cyc_v), 32'h4);
    chk("ws store early hexokay", 32'(early_v), 32'h0);
    chk("ws store hexokay", 32'(src_hexokay), 32'h1);
    @(posedge clk); #1;
    ws_cfg = 0;
    xfer(8'd0, 32'h600, 1'b0, 1'b0, 32'h0, ok_v, resp_v, rd_v, dtr_v, cyc_v, early_v);
    chk("ws readback", rd_v, 32'h600D0600);
    err_cfg = 1'b1;
    xfer(8'd1, 32'h800, 1'b0, 1'b1, 32'h0, ok_v, resp_v, rd_v, dtr_v, cyc_v, early_v);
    chk("err load cycles", 32'(cyc_v), 32'h2);
    chk("err load hresp", 32'(resp_v), 32'h1);
    err_cfg = 1'b0;
    xfer(8'd1, 32'h800, 1'b1, 1'b1, 32'h1, ok_v, resp_v, rd_v, dtr_v, cyc_v, early_v);
    chk("err store dst_htrans", 32'(dtr_v), 32'h0);
    chk("err store hexokay", 32'(ok_v), 32'h0);
    xfer(8'd0, 32'h700, 1'b0, 1'b1, 32'h0, ok_v, resp_v, rd_v, dtr_v, cyc_v, early_v);
    chk("rst load hexokay", 32'(ok_v), 32'h1);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    xfer(8'd0, 32'h700, 1'b1, 1'b1, 32'h2, ok_v, resp_v, rd_v, dtr_v, cyc_v, early_v);
    chk("rst store dst_htrans", 32'(dtr_v), 32'h0);
    chk("rst store hexokay", 32'(ok_v), 32'h0);
    chk("rst store cycles", 32'(cyc_v), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
